sdram_refresh_scheduler: RTL and testbench

Schedules SDRAM auto-refresh commands so they land in idle windows of the Vector-06c expansion bus instead of colliding with ramdisk (kvaz) or floppy SoC traffic. Sits between the bus-timing logic and the SDRAM controller's `refresh` input, on the `clk_cpu` (24 MHz) domain. It accrues a refresh debt at a fixed interval and pays it off opportunistically. When the debt grows too large, it escalates to urgent refreshes and blocks disk traffic.

---
 rtl/sdram_refresh_scheduler.sv | 99 +++++++++
 tb/tb_sdram_refresh_scheduler.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sdram_refresh_scheduler.sv
`timescale 1ns/1ps
// Accrues SDRAM refresh debt on a fixed interval and issues refresh requests in
// idle expansion-bus windows, escalating to urgent refreshes when the debt grows.
module sdram_refresh_scheduler #(
  parameter int REFRESH_INTERVAL = 187,
  parameter int DEBT_MAX         = 8,
  parameter int URGENT_LEVEL     = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       access_slot,
  input  logic       vu_pending,
  input  logic       disk_pending,
  input  logic       sdram_busy,
  output logic       refresh,
  output logic       hold_disk,
  output logic [3:0] debt,
  output logic       overrun
);

  localparam int            CW       = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam logic [CW-1:0] RELOAD   = CW'(REFRESH_INTERVAL - 1);
  localparam logic [3:0]    DEBT_TOP = 4'(DEBT_MAX);
  localparam logic [3:0]    URGENT   = 4'(URGENT_LEVEL);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    state_q, state_d;
  logic [3:0]    debt_q, debt_d;
  logic          ovr_q, ovr_d;
  logic          tick, accept, urgent, launch;

  always_comb begin
    tick  = (cnt_q == '0);
    cnt_d = tick ? RELOAD : (cnt_q - CW'(1));
  end

  always_comb begin
    urgent = (debt_q >= URGENT);
    accept = (state_q == ST_REQ) && sdram_busy;
    // Vector-side traffic always wins: never launch while it is pending.
    launch = (debt_q != 4'd0) && !sdram_busy && !vu_pending &&
             ((access_slot && !disk_pending) || urgent);
  end

  always_comb begin
    debt_d = debt_q;
    ovr_d  = ovr_q;
    if (tick && !accept) begin
      if (debt_q >= DEBT_TOP) begin
        ovr_d = 1'b1;
      end else begin
        debt_d = debt_q + 4'd1;
      end
    end else if (accept && !tick) begin
      debt_d = debt_q - 4'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (launch) state_d = ST_REQ;
      // Acceptance is checked first so it wins over a same-cycle abort.
      ST_REQ: begin
        if (sdram_busy) begin
          state_d = ST_RUN;
        end else if (vu_pending) begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN:  if (!sdram_busy) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= RELOAD;
      state_q <= ST_IDLE;
      debt_q  <= 4'd0;
      ovr_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      debt_q  <= debt_d;
      ovr_q   <= ovr_d;
    end
  end

  assign refresh   = (state_q == ST_REQ);
  assign hold_disk = (debt_q >= URGENT) || (state_q != ST_IDLE);
  assign debt      = debt_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_sdram_refresh_scheduler.sv
`timescale 1ns/1ps
// Self-checking bench for sdram_refresh_scheduler: vector table plus hand-written
// corner sequences, with expected outputs queued at drive time and popped at sample time.
module tb_sdram_refresh_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       access_slot = 1'b0;
  logic       vu_pending = 1'b0;
  logic       disk_pending = 1'b0;
  logic       sdram_busy = 1'b0;
  logic       refresh;
  logic       hold_disk;
  logic [3:0] debt;
  logic       overrun;

  int n_checks = 0;
  int n_fail   = 0;

  sdram_refresh_scheduler #(
    .REFRESH_INTERVAL(187),
    .DEBT_MAX(8),
    .URGENT_LEVEL(6)
  ) dut (
    .clk(clk),
    .reset(reset),
    .access_slot(access_slot),
    .vu_pending(vu_pending),
    .disk_pending(disk_pending),
    .sdram_busy(sdram_busy),
    .refresh(refresh),
    .hold_disk(hold_disk),
    .debt(debt),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    bit         do_rst;
    int         adv;
    logic       slot, vu, disk, busy;
    logic       e_ref, e_hold;
    logic [3:0] e_debt;
    logic       e_ovr;
  } vec_t;

  typedef struct {
    string      name;
    logic       r, h;
    logic [3:0] d;
    logic       o;
  } exp_t;

  vec_t tbl[$];
  exp_t sb_q[$];

  task automatic add(input string name, input bit rst, input int adv,
                     input logic s, input logic v, input logic d, input logic b,
                     input logic r, input logic h, input logic [3:0] dbt, input logic o);
    vec_t t;
    t.name = name; t.do_rst = rst; t.adv = adv;
    t.slot = s; t.vu = v; t.disk = d; t.busy = b;
    t.e_ref = r; t.e_hold = h; t.e_debt = dbt; t.e_ovr = o;
    tbl.push_back(t);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic chk(input string name, input string field, input logic [3:0] act, input logic [3:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s: got %0d, required %0d", name, field, act, req);
    end
  endtask

  task automatic compare();
    exp_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard: got empty queue, required one entry");
    end else begin
      e = sb_q.pop_front();
      chk(e.name, "refresh", {3'b0, refresh}, {3'b0, e.r});
      chk(e.name, "hold_disk", {3'b0, hold_disk}, {3'b0, e.h});
      chk(e.name, "debt", debt, e.d);
      chk(e.name, "overrun", {3'b0, overrun}, {3'b0, e.o});
      $display("txn %-20s refresh=%0d hold_disk=%0d debt=%0d overrun=%0d", e.name, refresh, hold_disk, debt, overrun);
    end
  endtask

  // Drive inputs, queue the expectation, run adv cycles, then sample and compare.
  task automatic step(input string name, input int adv,
                      input logic s, input logic v, input logic d, input logic b,
                      input logic r, input logic h, input logic [3:0] dbt, input logic o);
    exp_t e;
    access_slot = s; vu_pending = v; disk_pending = d; sdram_busy = b;
    e.name = name; e.r = r; e.h = h; e.d = dbt; e.o = o;
    sb_q.push_back(e);
    repeat (adv) @(negedge clk);
    compare();
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    // Idle bus, slot never offered: debt climbs to urgent, then a controller
    // model accepts two cycles after the request.
    add("reset_state",   1, 0,    0,0,0,0, 0,0,4'd0,0);
    add("pre_first_tick",0, 186,  0,0,0,0, 0,0,4'd0,0);
    add("first_tick",    0, 1,    0,0,0,0, 0,0,4'd1,0);
    add("debt5",         0, 934,  0,0,0,0, 0,0,4'd5,0);
    add("debt6_urgent",  0, 1,    0,0,0,0, 0,1,4'd6,0);
    add("urgent_req",    0, 1,    0,0,0,0, 1,1,4'd6,0);
    add("req_wait",      0, 1,    0,0,0,0, 1,1,4'd6,0);
    add("urgent_accept", 0, 1,    0,0,0,1, 0,1,4'd5,0);
    add("run_hold",      0, 1,    0,0,0,1, 0,1,4'd5,0);
    add("run_exit",      0, 1,    0,0,0,0, 0,0,4'd5,0);
    // Controller permanently busy: saturation and sticky overrun.
    add("sat_reset",     1, 0,    0,0,0,1, 0,0,4'd0,0);
    add("sat_debt7",     0, 1495, 0,0,0,1, 0,1,4'd7,0);
    add("sat_debt8",     0, 1,    0,0,0,1, 0,1,4'd8,0);
    add("sat_pre_ovr",   0, 186,  0,0,0,1, 0,1,4'd8,0);
    add("sat_overrun",   0, 1,    0,0,0,1, 0,1,4'd8,1);
    add("sat_sticky",    0, 300,  0,0,0,1, 0,1,4'd8,1);

    foreach (tbl[i]) begin
      if (tbl[i].do_rst) begin
        access_slot = tbl[i].slot; vu_pending = tbl[i].vu;
        disk_pending = tbl[i].disk; sdram_busy = tbl[i].busy;
        do_reset();
      end
      step(tbl[i].name, tbl[i].adv, tbl[i].slot, tbl[i].vu, tbl[i].disk, tbl[i].busy,
           tbl[i].e_ref, tbl[i].e_hold, tbl[i].e_debt, tbl[i].e_ovr);
    end

    // Opportunistic slot gated by disk traffic, then REQ abort vs acceptance.
    access_slot = 0; vu_pending = 0; disk_pending = 0; sdram_busy = 0;
    do_reset();
    step("b_debt2",        374, 0,0,0,0, 0,0,4'd2,0);
    step("b_slot_disk",    1,   1,0,1,0, 0,0,4'd2,0);
    step("b_slot_go",      1,   1,0,0,0, 1,1,4'd2,0);
    step("b_accept",       1,   0,0,0,1, 0,1,4'd1,0);
    step("b_run_exit",     1,   0,0,0,0, 0,0,4'd1,0);
    step("c_req",          1,   1,0,0,0, 1,1,4'd1,0);
    step("c_abort",        1,   0,1,0,0, 0,0,4'd1,0);
    step("c_req2",         1,   1,0,0,0, 1,1,4'd1,0);
    step("c_accept_wins",  1,   0,1,0,1, 0,1,4'd0,0);
    step("c_run_exit",     1,   0,0,0,0, 0,0,4'd0,0);
    step("c_tick",         178, 0,0,0,0, 0,0,4'd1,0);
    step("c_vu_blocks",    1,   1,1,0,0, 0,0,4'd1,0);
    step("c_busy_blocks",  1,   1,0,0,1, 0,0,4'd1,0);
    step("c_idle",         1,   0,0,0,0, 0,0,4'd1,0);

    // Tick landing on the acceptance edge leaves debt unchanged.
    do_reset();
    step("d_debt3",        561, 0,0,0,0, 0,0,4'd3,0);
    step("d_wait",         185, 0,0,0,0, 0,0,4'd3,0);
    step("d_slot",         1,   1,0,0,0, 1,1,4'd3,0);
    step("d_tick_accept",  1,   0,0,0,1, 0,1,4'd3,0);
    step("d_exit",         1,   0,0,0,0, 0,0,4'd3,0);

    // Asynchronous reset while in RUN with debt 4.
    do_reset();
    step("f_debt5",        935, 0,0,0,0, 0,0,4'd5,0);
    step("f_slot",         1,   1,0,0,0, 1,1,4'd5,0);
    step("f_run",          1,   0,0,0,1, 0,1,4'd4,0);
    #2;
    reset = 1'b1;
    #1;
    step("f_async_reset",  0,   0,0,0,1, 0,0,4'd0,0);
    sdram_busy = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    step("f_pre_tick",     186, 0,0,0,0, 0,0,4'd0,0);
    step("f_tick",         1,   0,0,0,0, 0,0,4'd1,0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
